// File: rtl/cla_nibble_serial_adder_if.sv
// cla_nibble_serial_adder_if: start/done request bus; master drives start,a,b,cin and slave returns busy,done,sum,cout,ovf
interface cla_nibble_serial_adder_if #(parameter int NIBBLES = 4);
  logic start;
  logic [4*NIBBLES-1:0] a;
  logic [4*NIBBLES-1:0] b;
  logic cin;
  logic busy;
  logic done;
  logic [4*NIBBLES-1:0] sum;
  logic cout;
  logic ovf;
  modport master (output start, a, b, cin, input busy, done, sum, cout, ovf);
  modport slave (input start, a, b, cin, output busy, done, sum, cout, ovf);
endinterface

// File: rtl/cla_nibble_serial_adder.sv
// cla_nibble_serial_adder: adds a+b+cin one nibble per cycle through one shared 4-bit CLA; ports clk, rst, bus (slave: start/a/b/cin in, busy/done/sum/cout/ovf out)
module CLA_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] s,
  output logic       c_out
);
  logic [3:0] g;
  logic [3:0] p;
  logic [4:1] c;
  always_comb begin
    g = a & b;
    p = a ^ b;
    c[1] = g[0] | (p[0] & c_in);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_in);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]) | (&p & c_in);
    s = p ^ {c[3:1], c_in};
    c_out = c[4];
  end
endmodule

module cla_nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input logic clk,
  input logic rst,
  cla_nibble_serial_adder_if.slave bus
);
  localparam int W = 4 * NIBBLES;
  localparam int IW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [W-1:0] op_a_q, op_a_d, op_b_q, op_b_d, sum_q, sum_d;
  logic [IW-1:0] idx_q, idx_d;
  logic carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
  logic accept, run, last;
  logic [3:0] s;
  logic c_out;
  CLA_4bit u_cla (
    .a(op_a_q[4*idx_q +: 4]),
    .b(op_b_q[4*idx_q +: 4]),
    .c_in(carry_q),
    .s(s),
    .c_out(c_out)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_a_q <= '0;
      op_b_q <= '0;
      sum_q <= '0;
      idx_q <= '0;
      carry_q <= 1'b0;
      cout_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_a_q <= op_a_d;
      op_b_q <= op_b_d;
      sum_q <= sum_d;
      idx_q <= idx_d;
      carry_q <= carry_d;
      cout_q <= cout_d;
      ovf_q <= ovf_d;
    end
  end
  always_comb begin
    accept = bus.start && (state_q == IDLE || state_q == DONE);
    run = state_q == RUN;
    last = idx_q == IW'(NIBBLES - 1);
    state_d = accept ? RUN : run ? (last ? DONE : RUN) : IDLE;
  end
  always_comb begin
    op_a_d = accept ? bus.a : op_a_q;
    op_b_d = accept ? bus.b : op_b_q;
    carry_d = accept ? bus.cin : run ? c_out : carry_q;
    idx_d = accept ? '0 : (run && !last) ? idx_q + 1'b1 : idx_q;
    sum_d = accept ? '0 : sum_q;
    if (run) sum_d[4*idx_q +: 4] = s;
    cout_d = (run && last) ? c_out : cout_q;
    // top-nibble S3 is the sign of the result; overflow when like-signed operands flip it
    ovf_d = (run && last) ? (op_a_q[W-1] == op_b_q[W-1]) && (s[3] != op_a_q[W-1]) : ovf_q;
  end
  always_comb begin
    bus.busy = state_q == RUN;
    bus.done = state_q == DONE;
    bus.sum = sum_q;
    bus.cout = cout_q;
    bus.ovf = ovf_q;
  end
endmodule

// File: tb/tb_cla_nibble_serial_adder.sv
// tb_cla_nibble_serial_adder: table vectors, corner sequences and a random sweep checked through a result scoreboard
module tb_cla_nibble_serial_adder;
  localparam int N = 4;
  typedef struct packed {logic [15:0] sum; logic cout; logic ovf;} res_t;
  typedef struct packed {logic [15:0] a; logic [15:0] b; logic cin; res_t r;} vec_t;
  logic clk = 0;
  logic rst = 1;
  int n_cmp = 0;
  int n_err = 0;
  int n_acc = 0;
  int n_done = 0;
  res_t q[$];
  vec_t tbl[6];
  cla_nibble_serial_adder_if #(.NIBBLES(N)) bus ();
  cla_nibble_serial_adder #(.NIBBLES(N)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic res_t model(input logic [15:0] a, input logic [15:0] b, input logic cin);
    logic [16:0] t;
    res_t r;
    t = {1'b0, a} + {1'b0, b} + {16'b0, cin};
    r.sum = t[15:0];
    r.cout = t[16];
    r.ovf = (a[15] == b[15]) && (t[15] != a[15]);
    return r;
  endfunction
  always @(negedge clk) begin
    if (bus.done) begin
      n_done++;
      if (q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
      else begin
        res_t e;
        e = q.pop_front();
        chk("sum", {16'b0, bus.sum}, {16'b0, e.sum});
        chk("cout", {31'b0, bus.cout}, {31'b0, e.cout});
        chk("ovf", {31'b0, bus.ovf}, {31'b0, e.ovf});
      end
    end
  end
  task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic cin, input res_t e);
    bus.start = 1;
    bus.a = a;
    bus.b = b;
    bus.cin = cin;
    q.push_back(e);
    n_acc++;
  endtask
  task automatic wait_done();
    int k;
    for (k = 0; k < 40 && !bus.done; k++) @(negedge clk);
    if (!bus.done) chk("done_timeout", 32'd0, 32'd1);
  endtask
  task automatic req(input logic [15:0] a, input logic [15:0] b, input logic cin, input res_t e);
    @(negedge clk);
    drive(a, b, cin, e);
    @(negedge clk);
    bus.start = 0;
    wait_done();
  endtask
  initial begin
    tbl[0] = '{16'h1234, 16'h4321, 1'b0, '{16'h5555, 1'b0, 1'b0}};
    tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, '{16'h0000, 1'b1, 1'b0}};
    tbl[2] = '{16'h7FFF, 16'h0000, 1'b1, '{16'h8000, 1'b0, 1'b1}};
    tbl[3] = '{16'h8000, 16'h8000, 1'b0, '{16'h0000, 1'b1, 1'b1}};
    tbl[4] = '{16'hFFFF, 16'hFFFF, 1'b1, '{16'hFFFF, 1'b1, 1'b0}};
    tbl[5] = '{16'h7FFF, 16'h7FFF, 1'b0, '{16'hFFFE, 1'b0, 1'b1}};
    bus.start = 0;
    bus.a = 0;
    bus.b = 0;
    bus.cin = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    chk("rst_busy", {31'b0, bus.busy}, 32'd0);
    chk("rst_done", {31'b0, bus.done}, 32'd0);
    chk("rst_sum", {16'b0, bus.sum}, 32'd0);
    chk("rst_cout", {31'b0, bus.cout}, 32'd0);
    chk("rst_ovf", {31'b0, bus.ovf}, 32'd0);
    @(negedge clk);
    drive(tbl[0].a, tbl[0].b, tbl[0].cin, tbl[0].r);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      bus.start = 0;
      chk($sformatf("busy_c%0d", k), {31'b0, bus.busy}, {31'b0, k <= 4});
      chk($sformatf("done_c%0d", k), {31'b0, bus.done}, {31'b0, k == 5});
    end
    for (int i = 1; i < 6; i++) req(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].r);
    @(negedge clk);
    drive(16'h1111, 16'h2222, 1'b0, '{16'h3333, 1'b0, 1'b0});
    repeat (2) @(negedge clk);
    bus.start = 1;
    bus.a = 16'hAAAA;
    bus.b = 16'hAAAA;
    bus.cin = 1;
    @(negedge clk);
    bus.start = 0;
    wait_done();
    drive(16'h0F0F, 16'hF0F0, 1'b1, '{16'h0000, 1'b1, 1'b0});
    @(negedge clk);
    bus.start = 0;
    chk("b2b_busy", {31'b0, bus.busy}, 32'd1);
    wait_done();
    req(16'h8000, 16'h8000, 1'b0, '{16'h0000, 1'b1, 1'b1});
    @(negedge clk);
    drive(16'h0123, 16'h0456, 1'b0, '{16'h0579, 1'b0, 1'b0});
    repeat (3) @(negedge clk);
    bus.start = 0;
    rst = 1;
    @(negedge clk);
    rst = 0;
    void'(q.pop_back());
    n_acc--;
    chk("mid_rst_busy", {31'b0, bus.busy}, 32'd0);
    chk("mid_rst_done", {31'b0, bus.done}, 32'd0);
    chk("mid_rst_sum", {16'b0, bus.sum}, 32'd0);
    chk("mid_rst_cout", {31'b0, bus.cout}, 32'd0);
    chk("mid_rst_ovf", {31'b0, bus.ovf}, 32'd0);
    repeat (10) @(negedge clk);
    req(16'h9ABC, 16'h6544, 1'b0, '{16'h0000, 1'b1, 1'b0});
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] ra, rb;
      logic rc;
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      req(ra, rb, rc, model(ra, rb, rc));
    end
    @(negedge clk);
    chk("done_count", n_done, n_acc);
    chk("queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
